// File: rtl/sha2_eddsa_pkg.sv
// Shared constants for the EdDSA SHA-2 message schedule: state encoding,
// round counts and the sigma rotate/shift amounts for both word widths.
package sha2_eddsa_pkg;

    localparam int ROUNDS_SHA256 = 64;
    localparam int ROUNDS_SHA512 = 80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        int unsigned s0_rot_a;
        int unsigned s0_rot_b;
        int unsigned s0_shr;
        int unsigned s1_rot_a;
        int unsigned s1_rot_b;
        int unsigned s1_shr;
    } sigma_cfg_t;

    localparam sigma_cfg_t SIGMA_CFG_256 = '{7, 18, 3, 17, 19, 10};
    localparam sigma_cfg_t SIGMA_CFG_512 = '{1, 8, 7, 19, 61, 6};

    function automatic sigma_cfg_t sigma_cfg(input int width);
        return (width == 32) ? SIGMA_CFG_256 : SIGMA_CFG_512;
    endfunction

endpackage

// File: rtl/sha2_sigma_eddsa.sv
// Combinational small-sigma functions of the SHA-2 message schedule,
// selected by word width (32 -> SHA-256, 64 -> SHA-512).
module sha2_sigma_eddsa
    import sha2_eddsa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_s0_in,
    input  logic [WIDTH-1:0] i_s1_in,
    output logic [WIDTH-1:0] o_sigma0,
    output logic [WIDTH-1:0] o_sigma1
);

    localparam sigma_cfg_t CFG = sigma_cfg(WIDTH);

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    assign o_sigma0 = rotr(i_s0_in, CFG.s0_rot_a) ^ rotr(i_s0_in, CFG.s0_rot_b) ^ (i_s0_in >> CFG.s0_shr);
    assign o_sigma1 = rotr(i_s1_in, CFG.s1_rot_a) ^ rotr(i_s1_in, CFG.s1_rot_b) ^ (i_s1_in >> CFG.s1_shr);

endmodule

// File: rtl/sha2_wsched_eddsa.sv
// SHA-2 message schedule: loads a 16-word block from RAM into a shift window,
// then streams W_t, K_t and W_t+K_t to the compression core with valid/ready.
module sha2_wsched_eddsa
    import sha2_eddsa_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int ROUNDS = ROUNDS_SHA512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ram_en_read,
    output logic [3:0]       ram_addr_read,
    input  logic [WIDTH-1:0] ram_data_out,
    output logic [6:0]       k_addr,
    input  logic [WIDTH-1:0] k_data,
    output logic             wk_valid,
    input  logic             wk_ready,
    output logic [WIDTH-1:0] w_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] wk_sum,
    output logic [6:0]       t_index,
    output logic             last
);

    localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_load_cnt;
    logic [6:0]       r_t;
    logic [WIDTH-1:0] r_win [16];

    logic [WIDTH-1:0] w_sigma0;
    logic [WIDTH-1:0] w_sigma1;
    logic [WIDTH-1:0] w_new_word;
    logic [WIDTH-1:0] w_shift_in;
    logic             w_handshake;
    logic             w_load_last;
    logic             w_shift_en;

    assign w_handshake = (r_state == ST_RUN) && wk_ready;
    assign w_load_last = (r_state == ST_LOAD) && (r_load_cnt == 5'd16);
    // RAM data lags the read by one cycle, so L0 issues a read but shifts nothing.
    assign w_shift_en  = ((r_state == ST_LOAD) && (r_load_cnt != 5'd0)) || w_handshake;
    assign w_shift_in  = (r_state == ST_LOAD) ? ram_data_out : w_new_word;

    sha2_sigma_eddsa #(.WIDTH(WIDTH)) u_sigma (
        .i_s0_in  (r_win[1]),
        .i_s1_in  (r_win[14]),
        .o_sigma0 (w_sigma0),
        .o_sigma1 (w_sigma1)
    );

    assign w_new_word = w_sigma1 + r_win[9] + w_sigma0 + r_win[0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_LOAD;
            ST_LOAD: if (w_load_last) w_state_next = ST_RUN;
            ST_RUN:  if (w_handshake && (r_t == T_LAST)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt <= 5'd0;
        end else if (r_state == ST_LOAD) begin
            r_load_cnt <= r_load_cnt + 5'd1;
        end else begin
            r_load_cnt <= 5'd0;
        end
    end

    // t wraps to 0 on the final handshake so k_addr idles at ROM word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= 7'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_t <= 7'd0;
        end else if (w_handshake) begin
            r_t <= (r_t == T_LAST) ? 7'd0 : r_t + 7'd1;
        end
    end

    // NOTE: the window is a register shift chain, not a RAM, so it can and
    // does take the asynchronous reset (w_out must read 0 after reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else if (w_shift_en) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_shift_in;
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign ram_en_read   = (r_state == ST_LOAD) && !r_load_cnt[4];
    assign ram_addr_read = r_load_cnt[3:0];
    assign k_addr        = r_t;
    assign t_index       = r_t;
    assign wk_valid      = (r_state == ST_RUN);
    assign last          = (r_state == ST_RUN) && (r_t == T_LAST);
    assign w_out         = r_win[0];
    assign k_out         = k_data;
    assign wk_sum        = r_win[0] + k_data;

endmodule
